// File: rtl/hp2vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hp2vga_pkg : shared widths, intensity codes and capture FSM states
// Revision   : 1.0
// ---------------------------------------------------------------------------
package hp2vga_pkg;

   localparam int BRAM_AW = 14;
   localparam int PIX_W   = 8;

   localparam logic [PIX_W-1:0] PIX_OFF  = 8'h00;
   localparam logic [PIX_W-1:0] PIX_HALF = 8'h80;
   localparam logic [PIX_W-1:0] PIX_FULL = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_VSKIP = 3'd1,
      ST_HSKIP = 3'd2,
      ST_CAPT  = 3'd3,
      ST_LEND  = 3'd4,
      ST_FDONE = 3'd5
   } cap_state_t;

   function automatic logic [PIX_W-1:0] pix_encode(input logic video, input logic half);
      logic [PIX_W-1:0] pix;
      if (!video) begin
         pix = PIX_OFF;
      end else if (half) begin
         pix = PIX_HALF;
      end else begin
         pix = PIX_FULL;
      end
      return pix;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hp_input_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hp_input_sync : 2-flop synchronisers, history flop and registered edge
//                 detect for the five raw HP display signals
// Revision      : 1.0
// ---------------------------------------------------------------------------
module hp_input_sync #(
   parameter bit SYNC_POL = 1'b1
)(
   input  logic clk,
   input  logic reset_n,
   input  logic hp_dotclk,
   input  logic hp_hs,
   input  logic hp_vs,
   input  logic hp_video,
   input  logic hp_half,
   output logic dot_rise,
   output logic hs_edge,
   output logic vs_edge,
   output logic video,
   output logic half
);

   // bit order: 0 dotclk, 1 hs, 2 vs, 3 video, 4 half
   logic [4:0] raw;
   logic [4:0] meta;
   logic [4:0] sync;
   logic [2:0] hist;

   logic hs_now;
   logic hs_prev;
   logic vs_now;
   logic vs_prev;

   assign raw     = {hp_half, hp_video, hp_vs, hp_hs, hp_dotclk};
   assign hs_now  = (sync[1] == SYNC_POL);
   assign hs_prev = (hist[1] == SYNC_POL);
   assign vs_now  = (sync[2] == SYNC_POL);
   assign vs_prev = (hist[2] == SYNC_POL);

   // video/half leave on the same edge as dot_rise so they stay aligned with it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta     <= '0;
         sync     <= '0;
         hist     <= '0;
         dot_rise <= 1'b0;
         hs_edge  <= 1'b0;
         vs_edge  <= 1'b0;
         video    <= 1'b0;
         half     <= 1'b0;
      end else begin
         meta     <= raw;
         sync     <= meta;
         hist     <= sync[2:0];
         dot_rise <= sync[0] & ~hist[0];
         hs_edge  <= hs_now & ~hs_prev;
         vs_edge  <= vs_now & ~vs_prev;
         video    <= sync[3];
         half     <= sync[4];
      end
   end

endmodule
`default_nettype wire

// File: rtl/hp_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hp_capture : locates the active window of each HP frame and writes one
//              intensity byte per captured dot into the frame BRAM
// Revision   : 1.0
// ---------------------------------------------------------------------------
module hp_capture
   import hp2vga_pkg::*;
#(
   parameter int H_SKIP   = 16,
   parameter int H_ACTIVE = 128,
   parameter int V_SKIP   = 4,
   parameter int V_ACTIVE = 96,      // H_ACTIVE*V_ACTIVE must fit the 14-bit address space
   parameter bit SYNC_POL = 1'b1
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               hp_dotclk,
   input  logic               hp_hs,
   input  logic               hp_vs,
   input  logic               hp_video,
   input  logic               hp_half,
   output logic [BRAM_AW-1:0] bram_addr,
   output logic [PIX_W-1:0]   bram_din,
   output logic               bram_we,
   output logic               frame_done,
   output logic               locked,
   output logic               short_line
);

   localparam logic [7:0]         HSKIP_LAST = 8'(H_SKIP - 1);
   localparam logic [7:0]         VSKIP_LAST = 8'(V_SKIP - 1);
   localparam logic [7:0]         HACT_LAST  = 8'(H_ACTIVE - 1);
   localparam logic [7:0]         VACT_LAST  = 8'(V_ACTIVE - 1);
   localparam logic [BRAM_AW-1:0] LINE_STEP  = BRAM_AW'(H_ACTIVE);

   logic dot_rise;
   logic hs_edge;
   logic vs_edge;
   logic video;
   logic half;

   hp_input_sync #(
      .SYNC_POL (SYNC_POL)
   ) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .hp_dotclk (hp_dotclk),
      .hp_hs     (hp_hs),
      .hp_vs     (hp_vs),
      .hp_video  (hp_video),
      .hp_half   (hp_half),
      .dot_rise  (dot_rise),
      .hs_edge   (hs_edge),
      .vs_edge   (vs_edge),
      .video     (video),
      .half      (half)
   );

   cap_state_t         state,     state_n;
   logic [7:0]         dot_cnt,   dot_cnt_n;
   logic [7:0]         line_cnt,  line_cnt_n;
   logic [BRAM_AW-1:0] line_base, line_base_n;
   logic [BRAM_AW-1:0] addr_q,    addr_n;
   logic [PIX_W-1:0]   din_q,     din_n;
   logic               we_q,      we_n;
   logic               fd_q,      fd_n;
   logic               locked_q,  locked_n;
   logic               short_q,   short_n;
   logic               adv;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         dot_cnt   <= '0;
         line_cnt  <= '0;
         line_base <= '0;
         addr_q    <= '0;
         din_q     <= '0;
         we_q      <= 1'b0;
         fd_q      <= 1'b0;
         locked_q  <= 1'b0;
         short_q   <= 1'b0;
      end else begin
         state     <= state_n;
         dot_cnt   <= dot_cnt_n;
         line_cnt  <= line_cnt_n;
         line_base <= line_base_n;
         addr_q    <= addr_n;
         din_q     <= din_n;
         we_q      <= we_n;
         fd_q      <= fd_n;
         locked_q  <= locked_n;
         short_q   <= short_n;
      end
   end

   always_comb begin
      state_n     = state;
      dot_cnt_n   = dot_cnt;
      line_cnt_n  = line_cnt;
      line_base_n = line_base;
      addr_n      = addr_q;
      din_n       = din_q;
      we_n        = 1'b0;
      fd_n        = 1'b0;
      locked_n    = locked_q;
      short_n     = short_q;
      adv         = 1'b0;

      if (!enable) begin
         state_n = ST_IDLE;
      end else if (vs_edge) begin
         // VS wins over HS and dots in every state; mid-frame it aborts the capture
         state_n     = ST_VSKIP;
         dot_cnt_n   = '0;
         line_cnt_n  = '0;
         line_base_n = '0;
         short_n     = 1'b0;
         if (state inside {ST_VSKIP, ST_HSKIP, ST_CAPT, ST_LEND}) begin
            locked_n = 1'b0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
            end
            ST_VSKIP: begin
               if (hs_edge) begin
                  if (dot_cnt == VSKIP_LAST) begin
                     state_n   = ST_HSKIP;
                     dot_cnt_n = '0;
                  end else begin
                     dot_cnt_n = dot_cnt + 8'd1;
                  end
               end
            end
            ST_HSKIP: begin
               if (hs_edge) begin
                  dot_cnt_n = '0;
               end else if (dot_rise) begin
                  if (dot_cnt == HSKIP_LAST) begin
                     state_n   = ST_CAPT;
                     dot_cnt_n = '0;
                  end else begin
                     dot_cnt_n = dot_cnt + 8'd1;
                  end
               end
            end
            ST_CAPT: begin
               if (hs_edge) begin
                  short_n = 1'b1;
                  adv     = 1'b1;
               end else if (dot_rise) begin
                  we_n      = 1'b1;
                  addr_n    = line_base + {{(BRAM_AW-8){1'b0}}, dot_cnt};
                  din_n     = pix_encode(video, half);
                  dot_cnt_n = dot_cnt + 8'd1;
                  if (dot_cnt == HACT_LAST) begin
                     // the final write of the frame completes it; no trailing HS needed
                     if (line_cnt == VACT_LAST) begin
                        state_n  = ST_FDONE;
                        fd_n     = 1'b1;
                        locked_n = 1'b1;
                     end else begin
                        state_n = ST_LEND;
                     end
                  end
               end
            end
            ST_LEND: begin
               if (hs_edge) begin
                  adv = 1'b1;
               end
            end
            ST_FDONE: begin
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase

         if (adv) begin
            line_base_n = line_base + LINE_STEP;
            line_cnt_n  = line_cnt + 8'd1;
            dot_cnt_n   = '0;
            if (line_cnt == VACT_LAST) begin
               state_n  = ST_FDONE;
               fd_n     = 1'b1;
               locked_n = 1'b1;
            end else begin
               state_n = ST_HSKIP;
            end
         end
      end
   end

   // dropping enable kills a pending strobe in the same cycle
   assign bram_we    = we_q & enable;
   assign frame_done = fd_q & enable;
   assign bram_addr  = addr_q;
   assign bram_din   = din_q;
   assign locked     = locked_q;
   assign short_line = short_q;

endmodule
`default_nettype wire

// File: tb/tb_hp_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hp_capture : directed, table-driven bench for hp_capture
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_hp_capture;
   import hp2vga_pkg::*;

   typedef struct {
      logic       video;
      logic       half;
      logic [7:0] exp;
   } pix_vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        hp_dotclk;
   logic        hp_hs;
   logic        hp_vs;
   logic        hp_video;
   logic        hp_half;
   logic [13:0] bram_addr;
   logic [7:0]  bram_din;
   logic        bram_we;
   logic        frame_done;
   logic        locked;
   logic        short_line;

   int total = 0;
   int bad   = 0;
   int fd_cnt = 0;
   int per   = 4;

   logic [13:0] wa[$];
   logic [7:0]  wd[$];
   logic        wf[$];
   logic [7:0]  ed[$];
   pix_vec_t    tbl[6];

   always #5 clk = ~clk;

   hp_capture dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .hp_dotclk  (hp_dotclk),
      .hp_hs      (hp_hs),
      .hp_vs      (hp_vs),
      .hp_video   (hp_video),
      .hp_half    (hp_half),
      .bram_addr  (bram_addr),
      .bram_din   (bram_din),
      .bram_we    (bram_we),
      .frame_done (frame_done),
      .locked     (locked),
      .short_line (short_line)
   );

   always @(negedge clk) begin
      if (bram_we) begin
         wa.push_back(bram_addr);
         wd.push_back(bram_din);
         wf.push_back(frame_done);
      end
      if (frame_done) fd_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not reach the end, got timeout want finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear();
      wa.delete();
      wd.delete();
      wf.delete();
   endtask

   task automatic dot(input logic v, input logic h);
      hp_video  = v;
      hp_half   = h;
      hp_dotclk = 1'b1;
      tick(per);
      hp_dotclk = 1'b0;
      tick(per);
   endtask

   task automatic skip(input int n);
      repeat (n) dot(1'b1, 1'b0);
   endtask

   task automatic hs_pulse();
      hp_hs = 1'b1;
      tick(3);
      hp_hs = 1'b0;
      tick(3);
   endtask

   task automatic vs_pulse();
      hp_vs = 1'b1;
      tick(3);
      hp_vs = 1'b0;
      tick(3);
   endtask

   task automatic wait_we(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (bram_we) ok = 1'b1;
      end
   endtask

   function automatic logic pv(input int l, input int d);
      return ((l * 7 + d) % 3) != 0;
   endfunction

   function automatic logic ph(input int l, input int d);
      return ((l + d / 2) % 2) != 0;
   endfunction

   function automatic logic [7:0] enc(input logic v, input logic h);
      return !v ? 8'h00 : (h ? 8'h80 : 8'hFF);
   endfunction

   initial begin
      bit ok;
      int na;
      int nd;
      int fi;

      tbl[0] = '{1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b1, 8'h80};
      tbl[2] = '{1'b1, 1'b0, 8'hFF};
      tbl[3] = '{1'b0, 1'b1, 8'h00};
      tbl[4] = '{1'b1, 1'b1, 8'h80};
      tbl[5] = '{1'b1, 1'b0, 8'hFF};

      reset_n = 1'b0; enable = 1'b1;
      hp_dotclk = 1'b0; hp_hs = 1'b0; hp_vs = 1'b0; hp_video = 1'b0; hp_half = 1'b0;
      tick(4);
      chk("reset_outputs", 32'({bram_we, frame_done, locked, short_line, bram_addr, bram_din}), 0);
      reset_n = 1'b1;
      tick(4);

      // ---- nominal frame, dot clock at the fastest legal rate ----
      per = 2;
      vs_pulse();
      repeat (4) hs_pulse();
      for (int l = 0; l < 96; l++) begin
         skip(16);
         for (int d = 0; d < 128; d++) begin
            logic v;
            logic h;
            if (l == 0 && d < 6) begin
               v = tbl[d].video;
               h = tbl[d].half;
            end else begin
               v = pv(l, d);
               h = ph(l, d);
            end
            ed.push_back(enc(v, h));
            dot(v, h);
         end
         hs_pulse();
      end
      tick(10);

      chk("a_write_count", wa.size(), 12288);
      na = 0; nd = 0; fi = -1;
      for (int i = 0; i < wa.size(); i++) begin
         if (wa[i] != 14'(i)) na++;
         if (i >= ed.size() || wd[i] !== ed[i]) nd++;
         if (wf[i] && fi < 0) fi = i;
      end
      chk("a_addr_order_errs", na, 0);
      chk("a_data_errs", nd, 0);
      chk("a_done_pulses", fd_cnt, 1);
      chk("a_done_write_index", fi, 12287);
      chk("a_locked", 32'(locked), 1);
      chk("a_short_clear", 32'(short_line), 0);
      for (int i = 0; i < 6; i++) begin
         logic [7:0]  g;
         logic [13:0] a;
         g = (i < wd.size()) ? wd[i] : 8'hxx;
         a = (i < wa.size()) ? wa[i] : 14'hxxxx;
         chk($sformatf("pix%0d_data", i), 32'(g), 32'(tbl[i].exp));
         chk($sformatf("pix%0d_addr", i), 32'(a), i);
      end

      // ---- short line 3, abort by VS at line 50 ----
      per = 4;
      clear();
      vs_pulse();
      repeat (4) hs_pulse();
      for (int l = 0; l < 3; l++) begin
         skip(16);
         repeat (128) dot(1'b1, 1'b0);
         hs_pulse();
      end
      clear();
      skip(16);
      repeat (100) dot(1'b1, 1'b1);
      tick(8);
      chk("b3_count", wa.size(), 100);
      chk("b3_first", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 384);
      chk("b3_last", (wa.size() > 0) ? 32'(wa[wa.size()-1]) : 32'hFFFF_FFFF, 483);
      chk("b3_short_before_hs", 32'(short_line), 0);
      hs_pulse();
      tick(2);
      chk("b3_short_set", 32'(short_line), 1);
      clear();
      skip(16);
      repeat (3) dot(1'b1, 1'b0);
      tick(8);
      chk("b4_count", wa.size(), 3);
      chk("b4_first", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 512);
      hs_pulse();
      for (int l = 5; l < 50; l++) begin
         skip(16);
         hs_pulse();
      end
      clear();
      skip(16);
      repeat (4) dot(1'b1, 1'b0);
      tick(8);
      chk("b50_count", wa.size(), 4);
      chk("b50_first", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 6400);
      chk("b50_locked_held", 32'(locked), 1);
      clear();
      vs_pulse();
      tick(4);
      chk("b_abort_short_clr", 32'(short_line), 0);
      chk("b_abort_locked_clr", 32'(locked), 0);
      repeat (5) dot(1'b1, 1'b0);
      repeat (3) begin
         hs_pulse();
         repeat (2) dot(1'b1, 1'b0);
      end
      hs_pulse();
      skip(16);
      tick(4);
      chk("b_abort_no_writes", wa.size(), 0);
      dot(1'b1, 1'b1);
      tick(8);
      chk("b_restart_count", wa.size(), 1);
      chk("b_restart_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 0);
      chk("b_restart_data", (wd.size() > 0) ? 32'(wd[0]) : 32'hFFFF_FFFF, 32'h80);

      // ---- enable dropped on a write cycle ----
      clear();
      hp_video = 1'b1; hp_half = 1'b0; hp_dotclk = 1'b1;
      wait_we(ok);
      chk("c_we_seen", 32'(ok), 1);
      #2 enable = 1'b0;
      #1 chk("c_we_gated", 32'(bram_we), 0);
      @(posedge clk);
      #1 chk("c_state_idle", 32'(dut.state), 32'(ST_IDLE));
      @(negedge clk);
      hp_dotclk = 1'b0;
      tick(4);
      chk("c_gated_not_written", wa.size(), 0);
      enable = 1'b1;
      repeat (3) dot(1'b1, 1'b0);
      hs_pulse();
      skip(20);
      tick(4);
      chk("c_idle_no_writes", wa.size(), 0);
      vs_pulse();
      repeat (4) hs_pulse();
      skip(16);
      tick(4);
      chk("c_skip_no_writes", wa.size(), 0);
      dot(1'b1, 1'b0);
      tick(8);
      chk("c_resume_count", wa.size(), 1);
      chk("c_resume_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 0);

      // ---- asynchronous reset during a write ----
      clear();
      dot(1'b1, 1'b1);
      dot(1'b1, 1'b1);
      hp_video = 1'b1; hp_half = 1'b0; hp_dotclk = 1'b1;
      wait_we(ok);
      chk("d_we_seen", 32'(ok), 1);
      chk("d_addr_pre", 32'(bram_addr), 3);
      chk("d_din_pre", 32'(bram_din), 32'hFF);
      #2 reset_n = 1'b0;
      #1;
      chk("d_rst_we", 32'(bram_we), 0);
      chk("d_rst_addr", 32'(bram_addr), 0);
      chk("d_rst_din", 32'(bram_din), 0);
      chk("d_rst_flags", 32'({frame_done, locked, short_line}), 0);
      @(negedge clk);
      reset_n = 1'b1;
      hp_dotclk = 1'b0;
      tick(4);
      clear();
      repeat (3) dot(1'b1, 1'b0);
      hs_pulse();
      repeat (3) dot(1'b1, 1'b0);
      tick(4);
      chk("d_no_write_without_vs", wa.size(), 0);
      vs_pulse();
      repeat (3) hs_pulse();
      skip(16);
      tick(4);
      chk("d_no_write_3hs", wa.size(), 0);
      hs_pulse();
      skip(16);
      tick(4);
      chk("d_no_write_skip", wa.size(), 0);
      dot(1'b1, 1'b0);
      tick(8);
      chk("d_first_count", wa.size(), 1);
      chk("d_first_addr", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFF_FFFF, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
